// File: rtl/alarm_keypad_ctrl_if.sv
// Keypad/alarm-core signal bundle for alarm_keypad_ctrl.
// master: keypad + alarm core side (drives keys and armed status).
// slave : the keypad controller.
// Optional macro ALARM_KEYPAD_DURESS_EN adds the duress_alarm signal.
interface alarm_keypad_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       is_armed;
    logic       arm_pulse;
    logic       disarm_pulse;
    logic       code_error;
    logic       locked_out;
    logic       entry_active;
    logic [3:0] digit_count;
`ifdef ALARM_KEYPAD_DURESS_EN
    logic       duress_alarm;

    modport master (
        output key_valid, key_code, is_armed,
        input  arm_pulse, disarm_pulse, code_error, locked_out,
               entry_active, digit_count, duress_alarm
    );
    modport slave (
        input  key_valid, key_code, is_armed,
        output arm_pulse, disarm_pulse, code_error, locked_out,
               entry_active, digit_count, duress_alarm
    );
`else
    modport master (
        output key_valid, key_code, is_armed,
        input  arm_pulse, disarm_pulse, code_error, locked_out,
               entry_active, digit_count
    );
    modport slave (
        input  key_valid, key_code, is_armed,
        output arm_pulse, disarm_pulse, code_error, locked_out,
               entry_active, digit_count
    );
`endif
endinterface

// File: rtl/alarm_keypad_ctrl.sv
// Keypad sequencer in front of the alarm core: collects digits, checks them
// against PIN, issues one-cycle arm/disarm/code_error strobes, and locks the
// keypad out after MAX_FAILS consecutive bad codes.
// Optional macro ALARM_KEYPAD_DURESS_EN adds DURESS_PIN and a sticky
// duress_alarm output.
module alarm_keypad_ctrl #(
    parameter int          CODE_LEN    = 4,
    parameter logic [31:0] PIN         = 32'h0000_1234,
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCKOUT_CYC = 500_000_000
`ifdef ALARM_KEYPAD_DURESS_EN
    ,
    parameter logic [31:0] DURESS_PIN  = 32'h0000_1235
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ENA,
    alarm_keypad_ctrl_if.slave  kp
);
    localparam int BUF_W  = CODE_LEN * 4;
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int LK_W   = $clog2(LOCKOUT_CYC + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LK_W-1:0]   LK_LAST    = LK_W'(LOCKOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
    localparam logic [3:0]        CNT_FULL   = 4'(CODE_LEN);
    localparam logic [BUF_W-1:0]  PIN_CODE   = PIN[BUF_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCKOUT} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [LK_W-1:0]     lk_q, lk_d;
    logic [FAIL_W-1:0]   fails_q, fails_d;
    // Strobes take two registered stages so they appear two cycles after ENTER.
    logic                arm_d, disarm_d, err_d;
    logic                arm_s1, disarm_s1, err_s1;
    logic                arm_q, disarm_q, err_q;

    logic is_digit, is_clear, is_enter, code_ok, match_pin, good;

    assign is_digit  = kp.key_valid && (kp.key_code <= 4'd9);
    assign is_clear  = kp.key_valid && (kp.key_code == 4'hA);
    assign is_enter  = kp.key_valid && (kp.key_code == 4'hB);
    // Short or over-long entries can never match, whatever the buffer holds.
    assign code_ok   = (cnt_q == CNT_FULL) && !ovf_q;
    assign match_pin = code_ok && (buf_q == PIN_CODE);

`ifdef ALARM_KEYPAD_DURESS_EN
    localparam logic [BUF_W-1:0] DURESS_CODE = DURESS_PIN[BUF_W-1:0];
    logic duress_q, duress_d, match_duress;
    assign match_duress = code_ok && (buf_q == DURESS_CODE);
    assign good         = match_pin || match_duress;
`else
    assign good         = match_pin;
`endif

    // Next-state and next-datapath logic for the entry sequencer.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        tmr_d    = tmr_q;
        lk_d     = lk_q;
        fails_d  = fails_q;
        arm_d    = 1'b0;
        disarm_d = 1'b0;
        err_d    = 1'b0;
`ifdef ALARM_KEYPAD_DURESS_EN
        duress_d = duress_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    buf_d   = BUF_W'({buf_q, kp.key_code});
                    cnt_d   = 4'd1;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (is_digit) begin
                    tmr_d = '0;
                    if (cnt_q < CNT_FULL) begin
                        buf_d = BUF_W'({buf_q, kp.key_code});
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (is_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else if (is_enter) begin
                    tmr_d   = '0;
                    state_d = S_CHECK;
                end else if (tmr_q == TMR_LAST) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
                if (good) begin
                    disarm_d = kp.is_armed;
                    arm_d    = !kp.is_armed;
                    fails_d  = '0;
                    state_d  = S_IDLE;
`ifdef ALARM_KEYPAD_DURESS_EN
                    if (!match_pin) duress_d = 1'b1;
`endif
                end else begin
                    err_d   = 1'b1;
                    fails_d = fails_q + FAIL_W'(1);
                    lk_d    = '0;
                    state_d = (fails_q + FAIL_W'(1) >= FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lk_q == LK_LAST) begin
                    lk_d    = '0;
                    fails_d = '0;
                    state_d = S_IDLE;
                end else begin
                    lk_d = lk_q + LK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and strobe pipeline registers; ENA=0 freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            tmr_q     <= '0;
            lk_q      <= '0;
            fails_q   <= '0;
            arm_s1    <= 1'b0;
            disarm_s1 <= 1'b0;
            err_s1    <= 1'b0;
            arm_q     <= 1'b0;
            disarm_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (ENA) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            tmr_q     <= tmr_d;
            lk_q      <= lk_d;
            fails_q   <= fails_d;
            arm_s1    <= arm_d;
            disarm_s1 <= disarm_d;
            err_s1    <= err_d;
            arm_q     <= arm_s1;
            disarm_q  <= disarm_s1;
            err_q     <= err_s1;
        end
    end

`ifdef ALARM_KEYPAD_DURESS_EN
    // Duress flag is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  duress_q <= 1'b0;
        else if (ENA)  duress_q <= duress_d;
    end
    assign kp.duress_alarm = duress_q;
`endif

    // Strobes are suppressed while the clock enable is low.
    assign kp.arm_pulse    = arm_q && ENA;
    assign kp.disarm_pulse = disarm_q && ENA;
    assign kp.code_error   = err_q && ENA;
    assign kp.locked_out   = (state_q == S_LOCKOUT);
    assign kp.entry_active = (state_q == S_ENTRY);
    assign kp.digit_count  = cnt_q;
endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// Directed bench for alarm_keypad_ctrl: arm/disarm, overflow, clear,
// lockout with expiry, inter-key timeout, clock-enable freeze, reset in lockout.
module tb_alarm_keypad_ctrl;
    logic clk;
    logic reset_n;
    logic ENA;
    int   errors = 0;
    int   checks = 0;

    alarm_keypad_ctrl_if kif ();

    alarm_keypad_ctrl #(
        .CODE_LEN   (4),
        .PIN        (32'h0000_1234),
        .TIMEOUT_CYC(20),
        .MAX_FAILS  (3),
        .LOCKOUT_CYC(40)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ENA    (ENA),
        .kp     (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        kif.key_valid = 1'b1;
        kif.key_code  = k;
        tick();
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
    endtask

    // Four digits, most significant nibble first, then ENTER.
    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
        press(4'hB);
    endtask

    initial begin
        reset_n       = 1'b0;
        ENA           = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        kif.is_armed  = 1'b0;
        tick();
        tick();
        check("rst_locked", kif.locked_out, 0);
        check("rst_entry", kif.entry_active, 0);
        check("rst_count", kif.digit_count, 0);
        check("rst_arm", kif.arm_pulse, 0);
        check("rst_err", kif.code_error, 0);
        reset_n = 1'b1;
        tick();

        // Correct code while disarmed: arm strobe two cycles after ENTER.
        kif.is_armed = 1'b0;
        press(4'h1);
        check("first_digit_entry", kif.entry_active, 1);
        check("first_digit_count", kif.digit_count, 1);
        press(4'h2); press(4'h3); press(4'h4);
        check("four_digit_count", kif.digit_count, 4);
        press(4'hB);
        check("check_not_entry", kif.entry_active, 0);
        tick();
        check("arm_early", kif.arm_pulse, 0);
        tick();
        check("arm_pulse", kif.arm_pulse, 1);
        check("arm_no_disarm", kif.disarm_pulse, 0);
        check("arm_no_err", kif.code_error, 0);
        tick();
        check("arm_one_cycle", kif.arm_pulse, 0);

        // Correct code while armed: disarm strobe.
        kif.is_armed = 1'b1;
        enter_code(16'h1234);
        tick();
        tick();
        check("disarm_pulse", kif.disarm_pulse, 1);
        check("disarm_no_arm", kif.arm_pulse, 0);
        tick();
        check("disarm_one_cycle", kif.disarm_pulse, 0);
        kif.is_armed = 1'b0;

        // Five digits: count saturates, code rejected (fail count 1).
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("ovf_count_sat", kif.digit_count, 4);
        press(4'hB);
        tick();
        tick();
        check("ovf_err", kif.code_error, 1);
        check("ovf_no_arm", kif.arm_pulse, 0);
        tick();
        check("ovf_err_one_cycle", kif.code_error, 0);

        // CLEAR aborts entry without touching the fail count.
        press(4'h1); press(4'h2); press(4'hA);
        check("clear_entry", kif.entry_active, 0);
        check("clear_count", kif.digit_count, 0);
        tick();
        tick();
        check("clear_no_err", kif.code_error, 0);

        // Second failure: still unlocked. Third: lockout (proves CLEAR kept count).
        enter_code(16'h9999);
        tick();
        tick();
        check("bad2_err", kif.code_error, 1);
        check("bad2_unlocked", kif.locked_out, 0);
        enter_code(16'h9999);
        tick();
        check("bad3_locked", kif.locked_out, 1);
        tick();
        check("bad3_err", kif.code_error, 1);
        // Keys during lockout are ignored.
        enter_code(16'h1234);
        check("lock_ignore_entry", kif.entry_active, 0);
        check("lock_ignore_count", kif.digit_count, 0);
        tick();
        tick();
        check("lock_ignore_arm", kif.arm_pulse, 0);
        // Lockout entered at edge N+1; last locked cycle follows edge N+40.
        repeat (31) tick();
        check("lock_last_cycle", kif.locked_out, 1);
        // Key on the expiry edge is dropped.
        press(4'h1);
        check("lock_expired", kif.locked_out, 0);
        check("expiry_key_entry", kif.entry_active, 0);
        check("expiry_key_count", kif.digit_count, 0);
        enter_code(16'h1234);
        tick();
        tick();
        check("post_lock_arm", kif.arm_pulse, 1);
        tick();

        // Inter-key timeout: entry abandoned 20 cycles after the last key.
        press(4'h1); press(4'h2);
        repeat (19) tick();
        check("timeout_not_yet", kif.entry_active, 1);
        tick();
        check("timeout_entry", kif.entry_active, 0);
        check("timeout_count", kif.digit_count, 0);
        repeat (5) tick();
        check("timeout_no_err", kif.code_error, 0);

        // ENA low freezes the timer and ignores keys.
        press(4'h1);
        repeat (10) tick();
        ENA = 1'b0;
        repeat (30) tick();
        press(4'h2);
        check("ena_frozen_entry", kif.entry_active, 1);
        check("ena_frozen_count", kif.digit_count, 1);
        ENA = 1'b1;
        repeat (9) tick();
        check("ena_resume_entry", kif.entry_active, 1);
        tick();
        check("ena_resume_timeout", kif.entry_active, 0);

        // Three fresh failures lock out; reset mid-lockout clears at once.
        for (int n = 1; n <= 3; n++) begin
            enter_code(16'h9999);
            tick();
            tick();
            check("triple_err", kif.code_error, 1);
            check("triple_locked", kif.locked_out, (n == 3) ? 1 : 0);
        end
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("reset_in_lock", kif.locked_out, 0);
        tick();
        check("reset_no_err", kif.code_error, 0);
        reset_n = 1'b1;
        tick();
        enter_code(16'h1234);
        tick();
        tick();
        check("post_reset_arm", kif.arm_pulse, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
